seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 129 ++++++++++++
 tb/tb_seq_detector_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial sequence detector (Mealy) for a runtime-loadable PAT_LEN-bit pattern.
// The first bit received is compared against pattern bit PAT_LEN-1.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous reset, active-high
//   x            serial data bit
//   x_valid      x is sampled only while high
//   overlap      1 = overlapping matches, 0 = matched bits are consumed
//   load         load pattern_in (takes priority over x_valid)
//   pattern_in   new pattern, bit PAT_LEN-1 is the first bit received
//   y            combinational match pulse, same cycle as the completing bit
//   armed        high once PAT_LEN-1 valid bits are held
//   match_count  saturating count of match pulses (only with SEQ_COUNT_EN)
//
// Build option: define SEQ_COUNT_EN to add the match_count port and counter.
//
// state | meaning
// FILL  | collecting the first PAT_LEN-1 valid bits, y held low
// ARMED | history full, every valid bit can complete a match

module seq_detector_param #(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b101,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern_in,
    output logic               y,
`ifdef SEQ_COUNT_EN
    output logic [CNT_W-1:0]   match_count,
`endif
    output logic               armed
);

    localparam int FILL_W = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_PENULT = FILL_W'(PAT_LEN - 2);

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_LEN-1:0] pat_r, pat_nxt;
    logic [PAT_LEN-2:0] hist, hist_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt;
    logic [PAT_LEN-1:0] window;

    // Candidate window: held history followed by the bit on the wire now.
    assign window = {hist, x};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILL;
            pat_r <= PATTERN;
            hist  <= '0;
            fill  <= '0;
        end else begin
            state <= state_nxt;
            pat_r <= pat_nxt;
            hist  <= hist_nxt;
            fill  <= fill_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_r;
        hist_nxt  = hist;
        fill_nxt  = fill;
        y         = 1'b0;
        if (load) begin
            pat_nxt   = pattern_in;
            hist_nxt  = '0;
            fill_nxt  = '0;
            state_nxt = FILL;
        end else if (x_valid) begin
            case (state)
                FILL: begin
                    hist_nxt = window[PAT_LEN-2:0];
                    fill_nxt = fill + 1'b1;
                    if (fill == FILL_PENULT) begin
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (window == pat_r) begin
                        y = 1'b1;
                        if (overlap) begin
                            hist_nxt = window[PAT_LEN-2:0];
                        end else begin
                            // Matched bits are consumed; refill from scratch.
                            hist_nxt  = '0;
                            fill_nxt  = '0;
                            state_nxt = FILL;
                        end
                    end else begin
                        hist_nxt = window[PAT_LEN-2:0];
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

    assign armed = (state == ARMED);

`ifdef SEQ_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (load) begin
            match_count <= '0;
        end else if (y && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + 1'b1;
        end
    end
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    localparam int PL   = 3;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          x;
    logic          x_valid;
    logic          overlap;
    logic          load;
    logic [PL-1:0] pattern_in;
    logic          y;
    logic          armed;
`ifdef SEQ_COUNT_EN
    logic [CW-1:0] match_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: pattern, queue of unconsumed valid bits (oldest first),
    // and match counter.
    logic [PL-1:0] m_pat;
    bit            mq[$];
    int            m_cnt;

    seq_detector_param #(
        .PAT_LEN(PL),
        .PATTERN(3'b101),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .x_valid    (x_valid),
        .overlap    (overlap),
        .load       (load),
        .pattern_in (pattern_in),
        .y          (y),
`ifdef SEQ_COUNT_EN
        .match_count(match_count),
`endif
        .armed      (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic bit model_armed();
        return mq.size() >= PL - 1;
    endfunction

    function automatic bit model_y(input bit v, input bit xb, input bit ld);
        logic [31:0] w;
        if (!v || ld || !model_armed()) return 1'b0;
        w = '0;
        foreach (mq[i]) w = {w[30:0], mq[i]};
        w = {w[30:0], xb};
        return w[PL-1:0] == m_pat;
    endfunction

    task automatic model_reset();
        m_pat = 3'b101;
        mq.delete();
        m_cnt = 0;
    endtask

    // One clock: drive, compare mid-cycle, advance model on the edge.
    // ey / ea are hand-computed y / armed values, -1 = not pinned.
    task automatic step(input bit v, input bit xb, input bit ld, input bit ov,
                        input logic [PL-1:0] pin, input int ey, input int ea);
        bit my;
        x_valid    = v;
        x          = xb;
        load       = ld;
        overlap    = ov;
        pattern_in = pin;
        #3;
        my = model_y(v, xb, ld);
        check("y", y, my);
        check("armed", armed, model_armed());
`ifdef SEQ_COUNT_EN
        check("match_count", match_count, m_cnt);
`endif
        if (ey >= 0) begin
            check("y_literal", y, ey);
            check("model_y_literal", my, ey);
        end
        if (ea >= 0) begin
            check("armed_literal", armed, ea);
            check("model_armed_literal", model_armed(), ea);
        end
        @(posedge clk);
        if (ld) begin
            m_pat = pin;
            mq.delete();
            m_cnt = 0;
        end else if (v) begin
            if (my && m_cnt < CMAX) m_cnt++;
            if (my && !ov) begin
                mq.delete();
            end else begin
                mq.push_back(xb);
                if (mq.size() > PL - 1) void'(mq.pop_front());
            end
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; x = 1'b0; x_valid = 1'b0; overlap = 1'b1; load = 1'b0; pattern_in = '0;
        model_reset();
        #2;
        check("reset_y", y, 0);
        check("reset_armed", armed, 0);
`ifdef SEQ_COUNT_EN
        check("reset_count", match_count, 0);
`endif
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // Overlapping, default pattern 101
        step(1, 1, 0, 1, 3'b000, 0, 0);
        step(1, 0, 0, 1, 3'b000, 0, 0);
        step(1, 1, 0, 1, 3'b000, 1, 1);
        step(1, 0, 0, 1, 3'b000, 0, 1);
        step(1, 1, 0, 1, 3'b000, 1, 1);

        // Non-overlapping
        step(0, 0, 1, 0, 3'b101, 0, 1);
        step(1, 1, 0, 0, 3'b000, 0, 0);
        step(1, 0, 0, 0, 3'b000, 0, 0);
        step(1, 1, 0, 0, 3'b000, 1, 1);
        step(1, 0, 0, 0, 3'b000, 0, 0);
        step(1, 1, 0, 0, 3'b000, 0, 0);
        step(0, 0, 0, 0, 3'b000, 0, 1);

        // Valid gaps
        step(0, 0, 1, 1, 3'b101, 0, 1);
        step(1, 1, 0, 1, 3'b000, 0, 0);
        step(0, 1, 0, 1, 3'b000, 0, 0);
        step(1, 0, 0, 1, 3'b000, 0, 0);
        step(0, 0, 0, 1, 3'b000, 0, 1);
        step(1, 1, 0, 1, 3'b000, 1, 1);

        // Load 110; load with a valid 1 discards that bit
        step(0, 0, 1, 1, 3'b110, 0, 1);
        step(1, 1, 1, 1, 3'b110, 0, 0);
        step(1, 1, 0, 1, 3'b000, 0, 0);
        step(1, 1, 0, 1, 3'b000, 0, 0);
        step(1, 0, 0, 1, 3'b000, 1, 1);
        step(1, 1, 0, 1, 3'b000, 0, 1);
        step(1, 1, 0, 1, 3'b000, 0, 1);
        step(1, 0, 0, 1, 3'b000, 1, 1);

        // Reset mid-stream
        step(0, 0, 1, 1, 3'b101, 0, 1);
        step(1, 1, 0, 1, 3'b000, 0, 0);
        step(1, 0, 0, 1, 3'b000, 0, 0);
        x_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check("midreset_armed", armed, 0);
        check("midreset_y", y, 0);
`ifdef SEQ_COUNT_EN
        check("midreset_count", match_count, 0);
`endif
        #1 reset = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 0, 1, 3'b000, 0, 0);
        step(1, 0, 0, 1, 3'b000, 0, 0);
        step(1, 1, 0, 1, 3'b000, 1, 1);

        // Counter saturation
        step(0, 0, 1, 1, 3'b101, 0, 1);
        step(1, 1, 0, 1, 3'b000, 0, 0);
        step(1, 0, 0, 1, 3'b000, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 1, 3'b000, 1, 1);
            step(1, 0, 0, 1, 3'b000, 0, 1);
        end
`ifdef SEQ_COUNT_EN
        check("count_saturated", match_count, 3);
`endif
        step(0, 0, 1, 1, 3'b101, 0, 1);
`ifdef SEQ_COUNT_EN
        check("count_after_load", match_count, 0);
`endif
        step(0, 0, 0, 1, 3'b000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
